// File: rtl/mem_wb_stage.sv
// MEM/WB pipeline register with write-once writeback across freezes.
// Optional retire counter enabled by defining WB_RETIRE_CNT_EN.
module mem_wb_stage #(
  parameter logic [3:0] RESET_DEST = 4'd0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        freeze,
  input  logic        mem_valid,
  input  logic        mem_wb_en,
  input  logic        mem_r_en,
  input  logic [31:0] mem_alu_res,
  input  logic [31:0] mem_rdata,
  input  logic [3:0]  mem_dest,
  output logic        writeBackEn,
  output logic [3:0]  Dest_wb,
  output logic [31:0] Result_wb,
  output logic        wb_valid,
  output logic [31:0] retire_cnt
);

  logic        r_valid;
  logic        r_wb_en;
  logic        r_r_en;
  logic [31:0] r_alu_res;
  logic [31:0] r_rdata;
  logic [3:0]  r_dest;
  logic        r_consumed;
  logic        w_wb_fire;

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_valid    <= 1'b0;
      r_wb_en    <= 1'b0;
      r_r_en     <= 1'b0;
      r_alu_res  <= '0;
      r_rdata    <= '0;
      r_dest     <= RESET_DEST;
      r_consumed <= 1'b0;
    end else if (!freeze) begin
      r_valid    <= mem_valid;
      r_wb_en    <= mem_wb_en;
      r_r_en     <= mem_r_en;
      r_alu_res  <= mem_alu_res;
      r_rdata    <= mem_rdata;
      r_dest     <= mem_dest;
      r_consumed <= 1'b0;
    end else if (r_valid) begin
      // A frozen instruction has already had its one write cycle.
      r_consumed <= 1'b1;
    end
  end

  assign w_wb_fire   = r_valid & r_wb_en & ~r_consumed;
  assign writeBackEn = w_wb_fire;
  assign Dest_wb     = r_dest;
  assign wb_valid    = r_valid;
  assign Result_wb   = r_r_en ? r_rdata : r_alu_res;

`ifdef WB_RETIRE_CNT_EN
  logic [31:0] r_retire_cnt;

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_retire_cnt <= '0;
    end else if (w_wb_fire) begin
      r_retire_cnt <= r_retire_cnt + 32'd1;
    end
  end

  assign retire_cnt = r_retire_cnt;
`else
  assign retire_cnt = '0;
`endif

endmodule

// File: doc/mem_wb_stage.md
MEM_WB_STAGE -- requirements
Module: mem_wb_stage

Interface
REQ-001 The block SHALL have the following ports, one per line: name  direction  width  meaning.
- clk  in  1  single clock; all state updates on rising edge.
- rst  in  1  synchronous, active-low reset.
- freeze  in  1  pipeline stall; holds the stage register.
- mem_valid  in  1  MEM stage presents an instruction.
- mem_wb_en  in  1  instruction writes a register.
- mem_r_en  in  1  instruction is a load; selects memory data.
- mem_alu_res  in  32  ALU result from MEM.
- mem_rdata  in  32  data-memory read data.
- mem_dest  in  4  destination register index.
- writeBackEn  out  1  register-file write enable.
- Dest_wb  out  4  register-file write index.
- Result_wb  out  32  register-file write data.
- wb_valid  out  1  stage register holds a live instruction.
- retire_cnt  out  32  count of retired write-back instructions.
REQ-002 The block SHALL have parameter RESET_DEST, default 4'd0, meaning the Dest_wb value after reset.

Function
REQ-003 The block SHALL capture the MEM inputs into a stage register on a rising edge when freeze=0: valid, wb_en, r_en, alu_res, rdata, dest.
REQ-004 When freeze=1 the stage register SHALL hold all fields unchanged.
REQ-005 Latency SHALL be one cycle: inputs captured at edge N drive the outputs after edge N.
REQ-006 Result_wb SHALL be the registered rdata when registered r_en=1, else the registered alu_res. This is combinational from the stage register.
REQ-007 Dest_wb SHALL equal the registered dest.
REQ-008 wb_valid SHALL equal the registered valid.
REQ-009 A 1-bit consumed flag SHALL be kept with these rules:
- Set to 1 at an edge where freeze=1 and wb_valid=1.
- Cleared to 0 at any edge where freeze=0.
REQ-010 writeBackEn SHALL be 1 only when all of these hold: registered valid=1, registered wb_en=1, and consumed=0. Each instruction therefore writes exactly once, in its first cycle in the stage, even if it is frozen there.
REQ-011 A valid entry with wb_en=0 (for example a store or branch) SHALL produce writeBackEn=0 and SHALL still count toward nothing in retire_cnt.
REQ-012 mem_valid=0 captured SHALL produce a bubble: wb_valid=0, writeBackEn=0, data fields don't-care.
REQ-013 The block SHALL NOT suppress a write to dest 0. Dest filtering is the register file's responsibility.
REQ-014 The register file samples on the falling clock edge, so Result_wb, Dest_wb and writeBackEn SHALL be stable from the rising edge through the following falling edge. No output may depend combinationally on the mem_* or freeze inputs.

Reset
REQ-015 When rst=0 at a rising edge, the following SHALL take effect regardless of freeze:
- valid, wb_en, r_en and consumed clear to 0.
- alu_res and rdata clear to 32'd0.
- dest loads RESET_DEST.
REQ-016 After reset the outputs SHALL be: writeBackEn=0, wb_valid=0, Result_wb=0, Dest_wb=RESET_DEST, retire_cnt=0.
REQ-017 Reset asserted mid-freeze SHALL discard the held instruction, which SHALL never be written back.

Configuration
REQ-018 The macro WB_RETIRE_CNT_EN SHALL control the retire counter.
- Defined: retire_cnt SHALL increment by 1 on each rising edge where writeBackEn=1. It is 32-bit and wraps from 32'hFFFFFFFF to 0.
- Undefined: no counter logic; retire_cnt SHALL be tied to 32'd0.

Verification
REQ-019 The bench SHALL cover these scenarios:
- Reset then idle: rst=0 for 2 cycles, then mem_valid=0 -> writeBackEn=0, wb_valid=0, Result_wb=0, retire_cnt=0.
- ALU op: mem_valid=1, wb_en=1, r_en=0, alu_res=32'h0000_0025, dest=4'd3 -> next cycle writeBackEn=1, Dest_wb=3, Result_wb=32'h25; register-file r3=32'h25 after the falling edge.
- Load op: r_en=1, alu_res=32'h100, rdata=32'hDEAD_BEEF, dest=4'd7 -> Result_wb=32'hDEADBEEF, Dest_wb=7.
- Freeze for 3 cycles with an ALU op in the stage -> writeBackEn=1 for exactly 1 cycle, Dest_wb/Result_wb held all 3 cycles, retire_cnt +1 only (macro defined).
- Store: wb_en=0, valid=1 -> writeBackEn=0, wb_valid=1, retire_cnt unchanged.
- rst=0 asserted during freeze with a valid op held -> next cycle wb_valid=0, writeBackEn=0, and no later write of that op.
